// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   INSTR_W / ADDR_W : default instruction and address widths
//   NOP              : all-zero instruction encoding
//   fetch_state_e    : prefetch request FSM states
package mips_pkg;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } fetch_state_e;
endpackage

// File: rtl/ifetch_prefetch_buffer_if.sv
// Bus bundle for the prefetch buffer.
//   ROM side    : o_mem_req/o_mem_addr out, i_mem_ack/i_mem_rdata in
//   Execute side: i_redirect/i_redirect_pc in
//   Decode side : o_valid/o_instr/o_pc out, i_ready in
// master = prefetch buffer, slave = its environment (ROM, execute, decode).
interface ifetch_prefetch_buffer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              o_mem_req;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              i_mem_ack;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              i_redirect;
  logic [ADDR_W-1:0] i_redirect_pc;
  logic              o_valid;
  logic [DATA_W-1:0] o_instr;
  logic [ADDR_W-1:0] o_pc;
  logic              i_ready;

  modport master (
    output o_mem_req, o_mem_addr,
    input  i_mem_ack, i_mem_rdata,
    input  i_redirect, i_redirect_pc,
    output o_valid, o_instr, o_pc,
    input  i_ready
  );

  modport slave (
    input  o_mem_req, o_mem_addr,
    output i_mem_ack, i_mem_rdata,
    output i_redirect, i_redirect_pc,
    input  o_valid, o_instr, o_pc,
    output i_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, DEPTH x WIDTH, DEPTH a power of two >= 2.
//   clk, rst_n : clock, asynchronous active-low reset (storage cleared to 0)
//   push/din   : write din when not full
//   pop/dout   : dout is the head entry; pop removes it when not empty
//   flush      : empties the FIFO; wins over push and pop
//   full, empty, count : occupancy
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/ifetch_prefetch_buffer.sv
// Instruction prefetch buffer between instruction ROM and decode.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (master)   : ROM req/ack handshake, execute redirect, decode valid/ready
// Fetches sequentially from fetch_pc, queues {pc, instr} in a DEPTH-entry
// FIFO, and flushes everything on a redirect. A request is only issued when
// the FIFO can absorb its data, so an ack is always pushable.
module ifetch_prefetch_buffer #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = mips_pkg::ADDR_W,
  parameter int unsigned       DATA_W   = mips_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                      i_clk,
  input logic                      i_rst_n,
  ifetch_prefetch_buffer_if.master bus
);
  import mips_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e              state, state_nx;
  logic [ADDR_W-1:0]         fetch_pc, fetch_pc_nx;
  logic [ADDR_W-1:0]         pend_pc, pend_pc_nx;
  logic [ADDR_W-1:0]         redir_pc;
  logic [CW-1:0]             count;
  logic                      full;
  logic                      empty;
  logic                      push;
  logic                      pop;
  logic                      room_after_push;
  logic [ADDR_W+DATA_W-1:0]  head;

  assign redir_pc = {bus.i_redirect_pc[ADDR_W-1:2], 2'b00};
  assign pop      = bus.o_valid && bus.i_ready && !bus.i_redirect;
  assign push     = (state == REQ) && bus.i_mem_ack && !bus.i_redirect;
  // count + 1 - pop < DEPTH, without the arithmetic
  assign room_after_push = pop || (count < CW'(DEPTH - 1));

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    pend_pc_nx  = pend_pc;
    unique case (state)
      IDLE: begin
        if (bus.i_redirect) fetch_pc_nx = redir_pc;
        else if (!full)     state_nx    = REQ;
      end
      REQ: begin
        if (bus.i_mem_ack) begin
          if (bus.i_redirect) begin
            fetch_pc_nx = redir_pc;
          end else begin
            fetch_pc_nx = fetch_pc + ADDR_W'(4);
            if (!room_after_push) state_nx = IDLE;
          end
        end else if (bus.i_redirect) begin
          // keep the outstanding address on the bus; park the target
          pend_pc_nx = redir_pc;
          state_nx   = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.i_redirect) pend_pc_nx = redir_pc;
        if (bus.i_mem_ack) begin
          fetch_pc_nx = bus.i_redirect ? redir_pc : pend_pc;
          state_nx    = REQ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      pend_pc  <= RESET_PC;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      pend_pc  <= pend_pc_nx;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.i_redirect),
    .din   ({fetch_pc, bus.i_mem_rdata}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.o_mem_req  = (state != IDLE);
  assign bus.o_mem_addr = fetch_pc;
  assign bus.o_valid    = !empty;
  assign {bus.o_pc, bus.o_instr} = head;
endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
module tb_ifetch_prefetch_buffer;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ifetch_prefetch_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ifetch_prefetch_buffer #(
    .DEPTH    (DEPTH),
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected FIFO contents (PCs), next expected request address
  logic [31:0] q[$];
  logic [31:0] popped[$];
  logic [31:0] next_addr;
  logic [31:0] prev_addr;
  logic [31:0] last_start;
  bit          discard;
  bit          prev_hold;
  bit          prev_idle_space;
  int          wait_cnt;
  int          cur_lat;
  int          fixed_lat = 0;
  bit          rand_lat  = 0;
  int          start_count;
  logic [31:0] first_start;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    popped.delete();
    next_addr       = RESET_PC;
    discard         = 0;
    prev_hold       = 0;
    prev_idle_space = 0;
    wait_cnt        = 0;
    cur_lat         = 0;
    start_count     = 0;
    first_start     = '0;
  endtask

  // One clock: check outputs at negedge, drive this cycle's inputs, advance model.
  task automatic step(input bit redir, input logic [31:0] tgt, input bit rdy);
    bit ack;
    int unsigned qs;
    @(negedge clk);
    qs = q.size();
    chk("valid", 32'(bus.o_valid), 32'(qs != 0));
    if (qs != 0) begin
      chk("pc", bus.o_pc, q[0]);
      chk("instr", bus.o_instr, rom(q[0]));
    end
    if (prev_idle_space) chk("req_resume", 32'(bus.o_mem_req), 32'd1);
    if (prev_hold) begin
      chk("req_hold", 32'(bus.o_mem_req), 32'd1);
      chk("addr_hold", bus.o_mem_addr, prev_addr);
    end else if (bus.o_mem_req) begin
      chk("req_addr", bus.o_mem_addr, next_addr);
      chk("req_room", 32'(qs < DEPTH), 32'd1);
      start_count++;
      if (start_count == 1) first_start = bus.o_mem_addr;
      last_start = bus.o_mem_addr;
      cur_lat = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
    end
    ack = bus.o_mem_req && (wait_cnt >= cur_lat);
    bus.i_mem_ack     = ack;
    bus.i_mem_rdata   = ack ? rom(bus.o_mem_addr) : 32'hDEAD_BEEF;
    bus.i_redirect    = redir;
    bus.i_redirect_pc = tgt;
    bus.i_ready       = rdy;

    if (qs != 0 && rdy && !redir) popped.push_back(bus.o_pc);
    if (redir) begin
      q.delete();
      next_addr = {tgt[31:2], 2'b00};
    end else begin
      if (qs != 0 && rdy) void'(q.pop_front());
      if (ack && !discard) q.push_back(bus.o_mem_addr);
    end
    if (ack && !discard && !redir) next_addr = bus.o_mem_addr + 32'd4;
    if (ack) discard = 0;
    else if (bus.o_mem_req && redir) discard = 1;
    prev_hold       = bus.o_mem_req && !ack;
    prev_addr       = bus.o_mem_addr;
    prev_idle_space = !bus.o_mem_req && (qs < DEPTH) && !redir;
    wait_cnt        = (bus.o_mem_req && !ack) ? wait_cnt + 1 : 0;
  endtask

  task automatic do_reset(input bit mid);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    if (mid) begin
      chk("rst_req_async", 32'(bus.o_mem_req), 32'd0);
      chk("rst_valid_async", 32'(bus.o_valid), 32'd0);
    end
    bus.i_mem_ack     = 1'b0;
    bus.i_mem_rdata   = '0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
    bus.i_ready       = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(bus.o_mem_req), 32'd0);
    chk("rst_addr", bus.o_mem_addr, RESET_PC);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_instr", bus.o_instr, 32'd0);
    chk("rst_pc", bus.o_pc, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    bus.i_mem_ack     = 1'b0;
    bus.i_mem_rdata   = '0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
    bus.i_ready       = 1'b0;
    model_clear();

    // Zero-wait ROM, decode always ready: back-to-back fetch
    fixed_lat = 0;
    do_reset(0);
    step(0, '0, 1);
    chk("t1_req_c1", 32'(bus.o_mem_req), 32'd1);
    chk("t1_addr_c1", bus.o_mem_addr, 32'h0);
    step(0, '0, 1);
    chk("t1_addr_c2", bus.o_mem_addr, 32'h4);
    chk("t1_valid_c2", 32'(bus.o_valid), 32'd1);
    chk("t1_pc_c2", bus.o_pc, 32'h0);
    chk("t1_instr_c2", bus.o_instr, 32'h1357_6420);
    step(0, '0, 1);
    chk("t1_addr_c3", bus.o_mem_addr, 32'h8);
    chk("t1_pc_c3", bus.o_pc, 32'h4);
    step(0, '0, 1);
    chk("t1_pc_c4", bus.o_pc, 32'h8);

    // Decode stalled: fill to DEPTH then stop requesting
    do_reset(0);
    repeat (10) step(0, '0, 0);
    chk("t2_req_count", 32'(start_count), 32'd4);
    chk("t2_req_low", 32'(bus.o_mem_req), 32'd0);
    chk("t2_pc_hold", bus.o_pc, 32'h0);
    start_count = 0;
    popped.delete();
    repeat (20) step(0, '0, 1);
    if (popped.size() >= 4) begin
      chk("t2_pop0", popped[0], 32'h0);
      chk("t2_pop1", popped[1], 32'h4);
      chk("t2_pop2", popped[2], 32'h8);
      chk("t2_pop3", popped[3], 32'hC);
    end else begin
      chk("t2_pop_count", 32'(popped.size()), 32'd4);
    end
    chk("t2_resume_addr", first_start, 32'h10);

    // Slow ROM with random decode stalls
    fixed_lat = 3;
    repeat (40) step(0, '0, 1'($urandom_range(0, 1)));

    // Redirect while the request for 0x8 is outstanding
    do_reset(0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(0, '0, 1);
      if (start_count > 0 && last_start == 32'h8 && bus.o_mem_req) found = 1;
    end
    chk("t4_reached_8", 32'(found), 32'd1);
    step(1, 32'h40, 1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(0, '0, 1);
      if (bus.o_valid) found = 1;
    end
    chk("t4_valid_seen", 32'(found), 32'd1);
    chk("t4_first_pc", bus.o_pc, 32'h40);

    // Redirect with ack and pop in the same cycle, misaligned target
    fixed_lat = 0;
    repeat (8) step(0, '0, 1);
    chk("t5_pre_req", 32'(bus.o_mem_req), 32'd1);
    chk("t5_pre_valid", 32'(bus.o_valid), 32'd1);
    step(1, 32'h103, 1);
    step(0, '0, 1);
    chk("t5_flushed", 32'(bus.o_valid), 32'd0);
    chk("t5_addr", bus.o_mem_addr, 32'h100);
    step(0, '0, 1);
    chk("t5_valid", 32'(bus.o_valid), 32'd1);
    chk("t5_pc", bus.o_pc, 32'h100);

    // Address wrap-around
    step(1, 32'hFFFF_FFFC, 1);
    step(0, '0, 1);
    chk("t6_addr_top", bus.o_mem_addr, 32'hFFFF_FFFC);
    step(0, '0, 1);
    chk("t6_addr_wrap", bus.o_mem_addr, 32'h0);
    chk("t6_pc_top", bus.o_pc, 32'hFFFF_FFFC);

    // Reset mid-request with data queued
    fixed_lat = 3;
    do_reset(0);
    repeat (6) step(0, '0, 0);
    chk("t7_pre_req", 32'(bus.o_mem_req), 32'd1);
    chk("t7_pre_valid", 32'(bus.o_valid), 32'd1);
    do_reset(1);
    step(0, '0, 1);
    chk("t7_first_req", 32'(bus.o_mem_req), 32'd1);
    chk("t7_first_addr", bus.o_mem_addr, RESET_PC);

    // Random traffic: latency, stalls and redirects
    rand_lat = 1;
    for (int i = 0; i < 1500; i++) begin
      bit          r;
      logic [31:0] t;
      r = ($urandom_range(0, 99) < 6);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                      : ($urandom & 32'h3FF);
      step(r, t, ($urandom_range(0, 99) < 75));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
